// File: rtl/axilite_pkg.sv
// -----------------------------------------------------------------------------
// axilite_pkg
// Shared definitions for the AXI4-Lite register-window slave: the AR-channel
// presentation states and the R/B response codes used by the read-data stage.
// No ports (package).
// -----------------------------------------------------------------------------
package axilite_pkg;

    // Presentation state of the AR front end.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESENT = 2'd1,
        ST_GAP     = 2'd2
    } ar_state_t;

    // AXI response codes.
    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_EXOKAY = 2'd1;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

endpackage

// File: rtl/axilite_addr_fifo.sv
// -----------------------------------------------------------------------------
// axilite_addr_fifo
// Generic DEPTH x WIDTH synchronous FIFO with registered storage and count.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   push, din    write request and data (ignored when full)
//   pop          read request (ignored when empty)
//   head         oldest entry, straight from the storage register
//   count        entries held
//   count_next   entries that will be held after this edge
//   full, empty  status flags derived from count
// -----------------------------------------------------------------------------
module axilite_addr_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [PTR_W:0]   count,
    output logic [PTR_W:0]   count_next,
    output logic             full,
    output logic             empty
);

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (push_ok && !pop_ok) begin
            count_next = count + (PTR_W+1)'(1);
        end else if (!push_ok && pop_ok) begin
            count_next = count - (PTR_W+1)'(1);
        end
    end

    // Storage is cleared on reset so the head reads zero afterwards.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_next;
        end
    end

endmodule

// File: rtl/axilite_read_addr.sv
// -----------------------------------------------------------------------------
// axilite_read_addr
// AXI4-Lite AR channel front end. Buffers accepted read addresses and
// presents the head entry to the read-data stage, one at a time, retiring it
// when the R handshake for it completes. A one-cycle addr_good gap after each
// retire keeps the registered read-data stage from re-issuing a beat.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   araddr/arprot  AR payload (arprot is ignored)
//   arvalid/arready AR handshake; arready is a register
//   addr/addr_good head address and its qualifier, to the read-data stage
//   deassert_addr  rready from the read-data stage
//   rvalid_mon     rvalid from the read-data stage
//   outstanding    entries currently held
// -----------------------------------------------------------------------------
module axilite_read_addr
    import axilite_pkg::*;
#(
    parameter int ADDR_SIZE = 32,
    parameter int DEPTH     = 2,
    parameter int PTR_W     = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_SIZE-1:0] araddr,
    input  logic [2:0]           arprot,
    input  logic                 arvalid,
    output logic                 arready,
    output logic [ADDR_SIZE-1:0] addr,
    output logic                 addr_good,
    input  logic                 deassert_addr,
    input  logic                 rvalid_mon,
    output logic [PTR_W:0]       outstanding
);

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

    ar_state_t      state;
    ar_state_t      state_next;
    logic           push;
    logic           retire;
    logic [PTR_W:0] count;
    logic [PTR_W:0] count_next;
    logic           fifo_full;
    logic           fifo_empty;
    logic           unused_bits;

    assign unused_bits = ^{arprot, fifo_full, fifo_empty};

    assign push        = arvalid && arready;
    assign addr_good   = (state == ST_PRESENT);
    assign retire      = addr_good && rvalid_mon && deassert_addr;
    assign outstanding = count;

    axilite_addr_fifo #(
        .WIDTH (ADDR_SIZE),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .din        (araddr),
        .pop        (retire),
        .head       (addr),
        .count      (count),
        .count_next (count_next),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    // Decisions look at count_next so an entry pushed this cycle is presented
    // on the very next cycle.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (count_next != '0) state_next = ST_PRESENT;
            ST_PRESENT: if (retire)           state_next = ST_GAP;
            ST_GAP:     state_next = (count_next != '0) ? ST_PRESENT : ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            arready <= 1'b1;
        end else begin
            state   <= state_next;
            arready <= (count_next != DEPTH_C);
        end
    end

endmodule

// File: tb/tb_axilite_read_addr.sv
module tb_axilite_read_addr;
    import axilite_pkg::*;

    localparam int AW    = 32;
    localparam int DEPTH = 2;
    localparam int PW    = $clog2(DEPTH);
    localparam logic [31:0] DATA_BYTES = 32'd16;  // 128-bit register window

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] araddr;
    logic [2:0]    arprot;
    logic          arvalid;
    logic          arready;
    logic [AW-1:0] addr;
    logic          addr_good;
    logic          rready;
    logic          rvalid;
    logic [PW:0]   outstanding;

    int n_checks = 0;
    int n_errors = 0;

    axilite_read_addr #(.ADDR_SIZE(AW), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .araddr        (araddr),
        .arprot        (arprot),
        .arvalid       (arvalid),
        .arready       (arready),
        .addr          (addr),
        .addr_good     (addr_good),
        .deassert_addr (rready),
        .rvalid_mon    (rvalid),
        .outstanding   (outstanding)
    );

    always #5 clk = ~clk;

    // Registered read-data stage stand-in: captures addr when presented,
    // raises rvalid the next cycle, drops it on the R handshake.
    logic [AW-1:0] r_addr;
    always @(posedge clk) begin
        if (!rst_n) begin
            rvalid <= 1'b0;
            r_addr <= '0;
        end else if (rvalid && rready) begin
            rvalid <= 1'b0;
        end else if (addr_good && !rvalid) begin
            rvalid <= 1'b1;
            r_addr <= addr;
        end
    end

    logic [31:0] beat_addr [$];
    logic [1:0]  beat_resp [$];
    initial forever begin
        @(posedge clk);
        if (rst_n && rvalid && rready) begin
            beat_addr.push_back(r_addr);
            beat_resp.push_back((r_addr >= DATA_BYTES) ? RESP_SLVERR : RESP_OKAY);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: an ordered list of accepted addresses. The head is
    // shown whenever the list is non-empty, except on the cycle right after a
    // retire.
    logic [31:0] q [$];
    bit          ret_prev = 1'b0;
    bit          model_on = 1'b0;

    initial forever begin
        bit exp_good, do_push, do_pop;
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            ret_prev = 1'b0;
            model_on = 1'b1;
        end else if (model_on) begin
            exp_good = (q.size() != 0) && !ret_prev;
            do_push  = arvalid && (q.size() != DEPTH);
            do_pop   = exp_good && rvalid && rready;
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back(araddr);
            ret_prev = do_pop;
        end
    end

    initial forever begin
        bit exp_good;
        @(negedge clk);
        if (model_on && rst_n) begin
            exp_good = (q.size() != 0) && !ret_prev;
            chk("arready", 32'(arready), 32'(q.size() != DEPTH));
            chk("addr_good", 32'(addr_good), 32'(exp_good));
            chk("outstanding", 32'(outstanding), 32'(q.size()));
            if (exp_good) chk("addr", addr, q[0]);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_beats(input string name, input logic [31:0] exp_a [$], input logic [1:0] exp_r [$]);
        chk({name, "_count"}, 32'(beat_addr.size()), 32'(exp_a.size()));
        for (int i = 0; i < exp_a.size() && i < beat_addr.size(); i++) begin
            chk($sformatf("%s_addr%0d", name, i), beat_addr[i], exp_a[i]);
            chk($sformatf("%s_resp%0d", name, i), 32'(beat_resp[i]), 32'(exp_r[i]));
        end
    endtask

    initial begin
        bit found;
        rst_n = 1'b0; araddr = '0; arprot = 3'd0; arvalid = 1'b0; rready = 1'b0;
        cyc(2);
        chk("rst_arready", 32'(arready), 32'd1);
        chk("rst_addr_good", 32'(addr_good), 32'd0);
        chk("rst_outstanding", 32'(outstanding), 32'd0);
        chk("rst_addr", addr, 32'd0);
        rst_n = 1'b1;
        cyc(1);

        // Single read
        beat_addr.delete(); beat_resp.delete();
        araddr = 32'h4; arvalid = 1'b1; rready = 1'b1; arprot = 3'd5;
        cyc(1);
        arvalid = 1'b0;
        chk("t1_good_c1", 32'(addr_good), 32'd1);
        chk("t1_outst_c1", 32'(outstanding), 32'd1);
        chk("t1_addr_c1", addr, 32'h4);
        cyc(1);
        chk("t1_rvalid_c2", 32'(rvalid), 32'd1);
        cyc(1);
        chk("t1_good_c3", 32'(addr_good), 32'd0);
        chk("t1_outst_c3", 32'(outstanding), 32'd0);
        cyc(3);
        chk_beats("t1", '{32'h4}, '{RESP_OKAY});

        // Back-to-back with R held off
        beat_addr.delete(); beat_resp.delete();
        rready = 1'b0;
        arvalid = 1'b1; araddr = 32'h0;
        cyc(1); araddr = 32'h4;
        cyc(1); araddr = 32'h8;
        chk("t2_arready_full", 32'(arready), 32'd0);
        chk("t2_outst_full", 32'(outstanding), 32'd2);
        cyc(1);
        chk("t2_outst_hold", 32'(outstanding), 32'd2);
        chk("t2_addr_head", addr, 32'h0);
        rready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            if (arready) begin found = 1'b1; break; end
        end
        chk("t2_arready_wait", 32'(found), 32'd1);
        chk("t2_outst_after_pop", 32'(outstanding), 32'd1);
        cyc(1);
        arvalid = 1'b0;
        chk("t2_outst_refill", 32'(outstanding), 32'd2);
        chk("t2_addr_second", addr, 32'h4);
        cyc(12);
        chk_beats("t2", '{32'h0, 32'h4, 32'h8}, '{RESP_OKAY, RESP_OKAY, RESP_OKAY});

        // Push and pop on the same edge at count=1
        beat_addr.delete(); beat_resp.delete();
        rready = 1'b0;
        arvalid = 1'b1; araddr = 32'h8;
        cyc(1); arvalid = 1'b0;
        cyc(1);
        chk("t3_rvalid", 32'(rvalid), 32'd1);
        arvalid = 1'b1; araddr = 32'hC; rready = 1'b1;
        cyc(1); arvalid = 1'b0;
        chk("t3_outst_same", 32'(outstanding), 32'd1);
        chk("t3_gap", 32'(addr_good), 32'd0);
        cyc(1);
        chk("t3_good_next", 32'(addr_good), 32'd1);
        chk("t3_addr_next", addr, 32'hC);
        cyc(6);
        chk_beats("t3", '{32'h8, 32'hC}, '{RESP_OKAY, RESP_OKAY});

        // R backpressure
        beat_addr.delete(); beat_resp.delete();
        rready = 1'b0;
        arvalid = 1'b1; araddr = 32'hC;
        cyc(1); arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            chk("t4_good_held", 32'(addr_good), 32'd1);
            chk("t4_addr_held", addr, 32'hC);
            chk("t4_outst_held", 32'(outstanding), 32'd1);
        end
        rready = 1'b1;
        cyc(1);
        chk("t4_gap", 32'(addr_good), 32'd0);
        chk("t4_outst_done", 32'(outstanding), 32'd0);
        cyc(1);
        chk("t4_idle", 32'(addr_good), 32'd0);
        cyc(2);
        chk_beats("t4", '{32'hC}, '{RESP_OKAY});

        // Reset with two entries held
        beat_addr.delete(); beat_resp.delete();
        rready = 1'b0;
        arvalid = 1'b1; araddr = 32'h0;
        cyc(1); araddr = 32'h4;
        cyc(1); arvalid = 1'b0;
        chk("t5_outst_pre", 32'(outstanding), 32'd2);
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        chk("t5_outst", 32'(outstanding), 32'd0);
        chk("t5_good", 32'(addr_good), 32'd0);
        chk("t5_arready", 32'(arready), 32'd1);
        chk("t5_addr", addr, 32'd0);
        rready = 1'b1;
        cyc(6);
        chk("t5_no_beats", 32'(beat_addr.size()), 32'd0);

        // Out-of-window address passes through and retires normally
        beat_addr.delete(); beat_resp.delete();
        arvalid = 1'b1; araddr = 32'h10;
        cyc(1); arvalid = 1'b0;
        chk("t6_addr", addr, 32'h10);
        cyc(5);
        chk("t6_outst", 32'(outstanding), 32'd0);
        chk_beats("t6", '{32'h10}, '{RESP_SLVERR});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
